iface_responder: RTL and testbench

IFACE_RESPONDER -- requirements
Module: iface_responder

---
 rtl/iface_pkg.sv | 23 ++
 rtl/iface_responder_if.sv | 36 +++
 rtl/iface_status_bank.sv | 29 ++
 rtl/iface_responder.sv | 137 +++++++++++++
 tb/tb_iface_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/iface_pkg.sv
// Shared constants, CSR offsets and FSM state encoding for the interface responder.
package iface_pkg;

    localparam int          AW_DEFAULT     = 22;
    localparam int          DW_DEFAULT     = 16;
    localparam logic [15:0] ID_VAL_DEFAULT = 16'hA55A;
    localparam logic [15:0] DEAD_CODE      = 16'hDEAD;

    localparam logic [3:0] CSR_ID        = 4'h0;
    localparam logic [3:0] CSR_CTRL      = 4'h1;
    localparam logic [3:0] CSR_STATUS    = 4'h2;
    localparam logic [3:0] CSR_SCRATCH   = 4'h3;
    localparam logic [3:0] CSR_TOKEN_CNT = 4'h4;
    localparam logic [3:0] CSR_DROP_CNT  = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/iface_responder_if.sv
// Host request/response bus plus the downstream memory request bus of the responder.
interface iface_responder_if
    import iface_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);
    logic [AW-1:0] interface_addr;
    logic          interface_wen;
    logic [DW-1:0] interface_wdata;
    logic          interface_ren;
    logic [DW-1:0] interface_rdata;
    logic          interface_rvalid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-2:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output interface_addr, interface_wen, interface_wdata, interface_ren,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  interface_rdata, interface_rvalid,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  interface_addr, interface_wen, interface_wdata, interface_ren,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output interface_rdata, interface_rvalid,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/iface_status_bank.sv
// Sticky status bits (clear-on-read, set wins) plus token and drop counters.
module iface_status_bank (
    input  logic        chip_clk,
    input  logic        asyn_rst_n,
    input  logic [7:0]  state_end,
    input  logic        token_finish,
    input  logic        status_clear,
    input  logic        drop_inc,
    output logic [8:0]  status,
    output logic [15:0] token_cnt,
    output logic [15:0] drop_cnt
);

    // New events OR in after the clear so a pulse coinciding with a read survives.
    always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            status    <= '0;
            token_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            status    <= (status & ~{9{status_clear}}) | {token_finish, state_end};
            token_cnt <= token_cnt + {15'd0, token_finish};
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/iface_responder.sv
// Host-facing responder: decodes CSR accesses locally, forwards the upper window to memory.
module iface_responder
    import iface_pkg::*;
#(
    parameter int          AW      = AW_DEFAULT,
    parameter int          DW      = DW_DEFAULT,
    parameter int          TIMEOUT = 255,
    parameter logic [15:0] ID_VAL  = ID_VAL_DEFAULT
) (
    input  logic               chip_clk,
    input  logic               asyn_rst_n,
    iface_responder_if.slave   bus,
    input  logic [7:0]         state_end,
    input  logic               token_finish,
    output logic               ctrl_start,
    output logic [14:0]        ctrl_cfg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [AW-2:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          we_q;
    logic          csr_rvalid_q;
    logic [TW-1:0] tmr;
    logic [15:0]   scratch;
    logic [15:0]   csr_rdata;
    logic [8:0]    status;
    logic [15:0]   token_cnt;
    logic [15:0]   drop_cnt;

    logic       idle, is_mem, acc_wr, acc_rd, drop_inc;
    logic       csr_wr, csr_rd, mem_start, timed_out, status_clear;
    logic [3:0] csr_off;

    assign idle         = (state == ST_IDLE);
    assign is_mem       = bus.interface_addr[AW-1];
    assign csr_off      = bus.interface_addr[3:0];
    assign acc_wr       = idle & bus.interface_wen;
    assign acc_rd       = idle & bus.interface_ren & ~bus.interface_wen;
    assign drop_inc     = (~idle & (bus.interface_wen | bus.interface_ren))
                        | (idle & bus.interface_wen & bus.interface_ren);
    assign csr_wr       = acc_wr & ~is_mem;
    assign csr_rd       = acc_rd & ~is_mem;
    assign mem_start    = (acc_wr | acc_rd) & is_mem;
    assign timed_out    = (tmr == TW'(TIMEOUT - 1));
    assign status_clear = csr_rd & (csr_off == CSR_STATUS);

    iface_status_bank u_status_bank (
        .chip_clk     (chip_clk),
        .asyn_rst_n   (asyn_rst_n),
        .state_end    (state_end),
        .token_finish (token_finish),
        .status_clear (status_clear),
        .drop_inc     (drop_inc),
        .status       (status),
        .token_cnt    (token_cnt),
        .drop_cnt     (drop_cnt)
    );

    always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (mem_start) state_nxt = ST_MEM_REQ;
            ST_MEM_REQ:  if (bus.mem_gnt) state_nxt = we_q ? ST_IDLE : ST_MEM_WAIT;
            ST_MEM_WAIT: if (bus.mem_rvalid || timed_out) state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        csr_rdata = 16'h0000;
        case (csr_off)
            CSR_ID:        csr_rdata = ID_VAL;
            CSR_CTRL:      csr_rdata = {ctrl_cfg, 1'b0};
            CSR_STATUS:    csr_rdata = {7'd0, status};
            CSR_SCRATCH:   csr_rdata = scratch;
            CSR_TOKEN_CNT: csr_rdata = token_cnt;
            CSR_DROP_CNT:  csr_rdata = drop_cnt;
            default:       csr_rdata = 16'h0000;
        endcase
    end

    // Timer restarts on grant; mem_rvalid wins over a timeout landing in the same cycle.
    always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            csr_rvalid_q <= 1'b0;
            tmr          <= '0;
            scratch      <= '0;
            ctrl_cfg     <= '0;
            ctrl_start   <= 1'b0;
        end else begin
            ctrl_start   <= csr_wr & (csr_off == CSR_CTRL) & bus.interface_wdata[0];
            csr_rvalid_q <= csr_rd;
            if (csr_wr && (csr_off == CSR_CTRL))    ctrl_cfg <= bus.interface_wdata[15:1];
            if (csr_wr && (csr_off == CSR_SCRATCH)) scratch  <= bus.interface_wdata[15:0];
            if (csr_rd) rdata_q <= DW'(csr_rdata);
            if (mem_start) begin
                addr_q  <= bus.interface_addr[AW-2:0];
                wdata_q <= bus.interface_wdata;
                we_q    <= bus.interface_wen;
            end
            if ((state == ST_MEM_REQ) && bus.mem_gnt) begin
                tmr <= '0;
            end else if (state == ST_MEM_WAIT) begin
                tmr <= tmr + TW'(1);
            end
            if (state == ST_MEM_WAIT) begin
                if (bus.mem_rvalid)  rdata_q <= bus.mem_rdata;
                else if (timed_out)  rdata_q <= DW'(DEAD_CODE);
            end
        end
    end

    assign bus.mem_req          = (state == ST_MEM_REQ);
    assign bus.mem_we           = (state == ST_MEM_REQ) & we_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.interface_rdata  = rdata_q;
    assign bus.interface_rvalid = csr_rvalid_q | (state == ST_RESP);

endmodule

// File: tb/tb_iface_responder.sv
// Directed self-checking bench for iface_responder: CSRs, memory window, timeout, drops, reset.
module tb_iface_responder;

    localparam int TIMEOUT = 255;

    logic        chip_clk;
    logic        asyn_rst_n;
    logic [7:0]  state_end;
    logic        token_finish;
    logic        ctrl_start;
    logic [14:0] ctrl_cfg;
    int          total;
    int          bad;
    int          wait_cycles;

    iface_responder_if #(.AW(22), .DW(16)) bus ();

    iface_responder #(.AW(22), .DW(16), .TIMEOUT(TIMEOUT), .ID_VAL(16'hA55A)) dut (
        .chip_clk     (chip_clk),
        .asyn_rst_n   (asyn_rst_n),
        .bus          (bus),
        .state_end    (state_end),
        .token_finish (token_finish),
        .ctrl_start   (ctrl_start),
        .ctrl_cfg     (ctrl_cfg)
    );

    initial chip_clk = 1'b0;
    always #5 chip_clk = ~chip_clk;

    task automatic tick();
        @(posedge chip_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for exactly one clock, then idles the host inputs.
    task automatic applyStimulus(input logic [21:0] addr, input logic wen, input logic ren, input logic [15:0] wdata);
        bus.interface_addr  = addr;
        bus.interface_wen   = wen;
        bus.interface_ren   = ren;
        bus.interface_wdata = wdata;
        tick();
        bus.interface_wen   = 1'b0;
        bus.interface_ren   = 1'b0;
        bus.interface_addr  = '0;
        bus.interface_wdata = '0;
    endtask

    task automatic csrRead(input string tag, input logic [21:0] addr, input logic [15:0] expected);
        applyStimulus(addr, 1'b0, 1'b1, 16'h0000);
        checkOutput({tag, "_rvalid"}, 32'(bus.interface_rvalid), 32'd1);
        checkOutput(tag, 32'(bus.interface_rdata), 32'(expected));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        asyn_rst_n          = 1'b0;
        state_end           = '0;
        token_finish        = 1'b0;
        bus.interface_addr  = '0;
        bus.interface_wen   = 1'b0;
        bus.interface_ren   = 1'b0;
        bus.interface_wdata = '0;
        bus.mem_gnt         = 1'b0;
        bus.mem_rvalid      = 1'b0;
        bus.mem_rdata       = '0;
        tick();
        tick();
        checkOutput("rst_rvalid", 32'(bus.interface_rvalid), 32'd0);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_ctrl_cfg", 32'(ctrl_cfg), 32'd0);
        checkOutput("rst_rdata", 32'(bus.interface_rdata), 32'd0);
        asyn_rst_n = 1'b1;
        tick();

        // Scratch write then read back
        applyStimulus(22'h000003, 1'b1, 1'b0, 16'h1234);
        checkOutput("wr_no_rvalid", 32'(bus.interface_rvalid), 32'd0);
        csrRead("scratch", 22'h000003, 16'h1234);
        tick();
        checkOutput("csr_rvalid_single", 32'(bus.interface_rvalid), 32'd0);

        // CTRL start pulse and configuration
        applyStimulus(22'h000001, 1'b1, 1'b0, 16'h0007);
        checkOutput("ctrl_start_hi", 32'(ctrl_start), 32'd1);
        checkOutput("ctrl_cfg", 32'(ctrl_cfg), 32'h0003);
        tick();
        checkOutput("ctrl_start_lo", 32'(ctrl_start), 32'd0);
        csrRead("ctrl_read", 22'h000001, 16'h0006);
        csrRead("id_read", 22'h000000, 16'hA55A);
        csrRead("unmapped", 22'h00000A, 16'h0000);

        // Memory read with delayed grant; two reads arrive mid-wait and are dropped
        applyStimulus(22'h200010, 1'b0, 1'b1, 16'h0000);
        checkOutput("mrd_req", 32'(bus.mem_req), 32'd1);
        checkOutput("mrd_addr", 32'(bus.mem_addr), 32'h000010);
        checkOutput("mrd_we", 32'(bus.mem_we), 32'd0);
        tick();
        tick();
        checkOutput("mrd_req_held", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        checkOutput("mrd_req_drop", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < 2) applyStimulus(22'h000003, 1'b0, 1'b1, 16'h0000);
            else       tick();
            checkOutput("mwait_no_rvalid", 32'(bus.interface_rvalid), 32'd0);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hBEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        checkOutput("mrd_rvalid", 32'(bus.interface_rvalid), 32'd1);
        checkOutput("mrd_rdata", 32'(bus.interface_rdata), 32'hBEEF);
        tick();
        checkOutput("mrd_rvalid_single", 32'(bus.interface_rvalid), 32'd0);
        checkOutput("rdata_hold", 32'(bus.interface_rdata), 32'hBEEF);

        // Memory write: granted immediately, no response
        applyStimulus(22'h200020, 1'b1, 1'b0, 16'h5555);
        checkOutput("mwr_we", 32'(bus.mem_we), 32'd1);
        checkOutput("mwr_addr", 32'(bus.mem_addr), 32'h000020);
        checkOutput("mwr_wdata", 32'(bus.mem_wdata), 32'h5555);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        checkOutput("mwr_done_req", 32'(bus.mem_req), 32'd0);
        checkOutput("mwr_no_rvalid", 32'(bus.interface_rvalid), 32'd0);

        // Simultaneous wen and ren: write wins, read dropped
        applyStimulus(22'h000003, 1'b1, 1'b1, 16'hCAFE);
        checkOutput("wr_rd_no_rvalid", 32'(bus.interface_rvalid), 32'd0);
        csrRead("drop_cnt", 22'h000005, 16'h0003);
        csrRead("scratch_cafe", 22'h000003, 16'hCAFE);

        // Sticky status and token counter
        state_end    = 8'h04;
        token_finish = 1'b1;
        tick();
        state_end    = 8'h00;
        token_finish = 1'b0;
        csrRead("status", 22'h000002, 16'h0104);
        csrRead("status_cleared", 22'h000002, 16'h0000);
        csrRead("token_cnt", 22'h000004, 16'h0001);
        state_end = 8'h01;
        csrRead("status_collide", 22'h000002, 16'h0000);
        state_end = 8'h00;
        csrRead("status_set_wins", 22'h000002, 16'h0001);

        // Memory read timeout
        applyStimulus(22'h200000, 1'b0, 1'b1, 16'h0000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        wait_cycles = 0;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            tick();
            if (bus.interface_rvalid) begin
                wait_cycles = i;
                break;
            end
        end
        checkOutput("timeout_latency", 32'(wait_cycles), 32'(TIMEOUT));
        checkOutput("timeout_rdata", 32'(bus.interface_rdata), 32'hDEAD);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1111;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("stray_rvalid", 32'(bus.interface_rvalid), 32'd0);
        checkOutput("stray_rdata", 32'(bus.interface_rdata), 32'hDEAD);

        // Reset in MEM_WAIT aborts the read and clears every CSR
        applyStimulus(22'h200004, 1'b0, 1'b1, 16'h0000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        tick();
        asyn_rst_n = 1'b0;
        #1;
        checkOutput("abort_rvalid", 32'(bus.interface_rvalid), 32'd0);
        checkOutput("abort_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("abort_ctrl_cfg", 32'(ctrl_cfg), 32'd0);
        tick();
        asyn_rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("abort_late_rvalid", 32'(bus.interface_rvalid), 32'd0);
        tick();
        checkOutput("abort_late_rvalid2", 32'(bus.interface_rvalid), 32'd0);
        csrRead("post_rst_ctrl", 22'h000001, 16'h0000);
        csrRead("post_rst_status", 22'h000002, 16'h0000);
        csrRead("post_rst_scratch", 22'h000003, 16'h0000);
        csrRead("post_rst_token", 22'h000004, 16'h0000);
        csrRead("post_rst_drop", 22'h000005, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
